// File: rtl/bsg_alu_pkg.sv
// Shared types for the bsg_alu family: the ALU opcode encoding and the checker FSM states.
package bsg_alu_pkg;

    typedef enum logic [1:0] {
        eAdd = 2'b00,
        eSub = 2'b01,
        eAnd = 2'b10,
        eOr  = 2'b11
    } bsg_alu_op_e;

    typedef enum logic {
        eRun  = 1'b0,
        eDone = 1'b1
    } bsg_alu_checker_state_e;

endpackage

// File: rtl/bsg_alu_golden.sv
// Combinational reference ALU: result modulo 2^width_p plus signed overflow for add/sub.
module bsg_alu_golden
    import bsg_alu_pkg::*;
#(
    parameter int width_p = 4
) (
    input  bsg_alu_op_e        control_i,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic [width_p-1:0] exp_o,
    output logic               exp_ov_o
);

    localparam int msb_lp = width_p - 1;

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        exp_o    = '0;
        exp_ov_o = 1'b0;
        unique case (control_i)
            eAdd: begin
                exp_o    = a_i + b_i;
                exp_ov_o = (a_i[msb_lp] == b_i[msb_lp]) && (exp_o[msb_lp] != a_i[msb_lp]);
            end
            eSub: begin
                exp_o    = a_i - b_i;
                exp_ov_o = (a_i[msb_lp] != b_i[msb_lp]) && (exp_o[msb_lp] != a_i[msb_lp]);
            end
            eAnd: exp_o = a_i & b_i;
            eOr:  exp_o = a_i | b_i;
        endcase
    end

endmodule

// File: rtl/bsg_alu_checker.sv
// Response-side ALU checker: two-stage golden compare, pass/error counting, first-mismatch capture.
module bsg_alu_checker
    import bsg_alu_pkg::*;
#(
    parameter int width_p     = 4,
    parameter int num_ops_p   = 16,
    parameter int cnt_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [1:0]             control_i,
    input  logic [width_p-1:0]     a_i,
    input  logic [width_p-1:0]     b_i,
    input  logic [width_p-1:0]     res_i,
    input  logic                   ov_i,
    output logic                   done_o,
    output logic [cnt_width_p-1:0] pass_cnt_o,
    output logic [cnt_width_p-1:0] err_cnt_o,
    output logic                   err_v_o,
    output logic [1:0]             err_control_o,
    output logic [width_p-1:0]     err_a_o,
    output logic [width_p-1:0]     err_b_o,
    output logic [width_p-1:0]     err_res_o,
    output logic [width_p-1:0]     err_exp_o
);

    localparam logic [cnt_width_p-1:0] num_ops_lp = cnt_width_p'(num_ops_p);
    localparam logic [cnt_width_p-1:0] one_lp     = cnt_width_p'(1);

    bsg_alu_checker_state_e state_r, state_n;
    logic [cnt_width_p-1:0] accepted_r;
    logic                   xfer;
    logic [width_p-1:0]     gold_exp;
    logic                   gold_ov;

    logic               s1_v_r, s1_ov_r, s1_exp_ov_r;
    bsg_alu_op_e        s1_control_r;
    logic [width_p-1:0] s1_a_r, s1_b_r, s1_res_r, s1_exp_r;

    logic               s2_v_r, s2_match_r;
    bsg_alu_op_e        s2_control_r;
    logic [width_p-1:0] s2_a_r, s2_b_r, s2_res_r, s2_exp_r;

    assign ready_o = reset_n_i && (state_r == eRun) && (accepted_r < num_ops_lp);
    assign xfer    = v_i && ready_o;
    assign done_o  = (state_r == eDone);

    bsg_alu_golden #(.width_p(width_p)) golden (
        .control_i (bsg_alu_op_e'(control_i)),
        .a_i       (a_i),
        .b_i       (b_i),
        .exp_o     (gold_exp),
        .exp_ov_o  (gold_ov)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= eRun;
            accepted_r <= '0;
        end else begin
            state_r <= state_n;
            if (xfer) accepted_r <= accepted_r + one_lp;
        end
    end

    // Stage 2 retires on the same edge that enters eDone, so counts are final when done rises.
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            eRun:  if ((accepted_r == num_ops_lp) && !s1_v_r) state_n = eDone;
            eDone: state_n = eDone;
        endcase
    end

    // NOTE: data flops are reset too, so a mid-stream reset leaves no stale transaction visible.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v_r       <= 1'b0;
            s1_control_r <= eAdd;
            s1_a_r       <= '0;
            s1_b_r       <= '0;
            s1_res_r     <= '0;
            s1_ov_r      <= 1'b0;
            s1_exp_r     <= '0;
            s1_exp_ov_r  <= 1'b0;
            s2_v_r       <= 1'b0;
            s2_match_r   <= 1'b0;
            s2_control_r <= eAdd;
            s2_a_r       <= '0;
            s2_b_r       <= '0;
            s2_res_r     <= '0;
            s2_exp_r     <= '0;
        end else begin
            s1_v_r <= xfer;
            if (xfer) begin
                s1_control_r <= bsg_alu_op_e'(control_i);
                s1_a_r       <= a_i;
                s1_b_r       <= b_i;
                s1_res_r     <= res_i;
                s1_ov_r      <= ov_i;
                s1_exp_r     <= gold_exp;
                s1_exp_ov_r  <= gold_ov;
            end
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                s2_match_r   <= (s1_res_r == s1_exp_r) && (s1_ov_r == s1_exp_ov_r);
                s2_control_r <= s1_control_r;
                s2_a_r       <= s1_a_r;
                s2_b_r       <= s1_b_r;
                s2_res_r     <= s1_res_r;
                s2_exp_r     <= s1_exp_r;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pass_cnt_o    <= '0;
            err_cnt_o     <= '0;
            err_v_o       <= 1'b0;
            err_control_o <= '0;
            err_a_o       <= '0;
            err_b_o       <= '0;
            err_res_o     <= '0;
            err_exp_o     <= '0;
        end else if (s2_v_r) begin
            if (s2_match_r) begin
                if (pass_cnt_o != '1) pass_cnt_o <= pass_cnt_o + one_lp;
            end else begin
                if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + one_lp;
                if (!err_v_o) begin
                    err_v_o       <= 1'b1;
                    err_control_o <= s2_control_r;
                    err_a_o       <= s2_a_r;
                    err_b_o       <= s2_b_r;
                    err_res_o     <= s2_res_r;
                    err_exp_o     <= s2_exp_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_alu_checker.sv
// Self-checking bench for bsg_alu_checker: directed op/overflow cases plus randomized traffic against an arithmetic model.
module tb_bsg_alu_checker;

    localparam int W = 4;
    localparam int N = 16;
    localparam int C = 8;

    logic         clk;
    logic         reset_n;
    logic         v;
    logic         ready_o;
    logic [1:0]   control;
    logic [W-1:0] a, b, res;
    logic         ov;
    logic         done_o;
    logic [C-1:0] pass_cnt_o, err_cnt_o;
    logic         err_v_o;
    logic [1:0]   err_control_o;
    logic [W-1:0] err_a_o, err_b_o, err_res_o, err_exp_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int           m_pass, m_err, m_sent, m_last_cyc;
    logic         m_err_v;
    logic [1:0]   m_ec;
    logic [W-1:0] m_ea, m_eb, m_eres, m_eexp;

    bsg_alu_checker #(.width_p(W), .num_ops_p(N), .cnt_width_p(C)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .v_i           (v),
        .ready_o       (ready_o),
        .control_i     (control),
        .a_i           (a),
        .b_i           (b),
        .res_i         (res),
        .ov_i          (ov),
        .done_o        (done_o),
        .pass_cnt_o    (pass_cnt_o),
        .err_cnt_o     (err_cnt_o),
        .err_v_o       (err_v_o),
        .err_control_o (err_control_o),
        .err_a_o       (err_a_o),
        .err_b_o       (err_b_o),
        .err_res_o     (err_res_o),
        .err_exp_o     (err_exp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference ALU computed with signed integer arithmetic and range checks.
    function automatic void model_alu(input logic [1:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                      output logic [W-1:0] e, output logic o);
        int sx, sy, r;
        sx = (int'(x) >= 2**(W-1)) ? int'(x) - 2**W : int'(x);
        sy = (int'(y) >= 2**(W-1)) ? int'(y) - 2**W : int'(y);
        e = '0;
        o = 1'b0;
        case (c)
            2'd0: begin r = sx + sy; e = W'(r); o = (r > 2**(W-1) - 1) || (r < -(2**(W-1))); end
            2'd1: begin r = sx - sy; e = W'(r); o = (r > 2**(W-1) - 1) || (r < -(2**(W-1))); end
            2'd2: e = x & y;
            default: e = x | y;
        endcase
    endfunction

    task automatic model_clear();
        m_pass = 0; m_err = 0; m_sent = 0; m_last_cyc = 0;
        m_err_v = 1'b0; m_ec = '0; m_ea = '0; m_eb = '0; m_eres = '0; m_eexp = '0;
    endtask

    // Drives one transaction and leaves v high; the caller lowers it when the burst ends.
    task automatic send(input logic [1:0] c, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] rr, input logic oo);
        logic [W-1:0] e;
        logic         o;
        int           budget;
        @(negedge clk);
        v = 1'b1; control = c; a = aa; b = bb; res = rr; ov = oo;
        budget = 0;
        while (ready_o !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (ready_o !== 1'b1) begin
            checks++; failures++;
            $display("FAIL send_timeout: ready_o=%b, required 1 within 50 cycles", ready_o);
        end else begin
            @(posedge clk);
            #1;
            m_sent++;
            m_last_cyc = cyc;
            model_alu(c, aa, bb, e, o);
            if (rr == e && oo == o) m_pass++;
            else begin
                m_err++;
                if (!m_err_v) begin
                    m_err_v = 1'b1; m_ec = c; m_ea = aa; m_eb = bb; m_eres = rr; m_eexp = e;
                end
            end
        end
    endtask

    task automatic send_rand(input bit wrong);
        logic [1:0]   c;
        logic [W-1:0] aa, bb, e;
        logic         o;
        c  = 2'($urandom_range(0, 3));
        aa = W'($urandom);
        bb = W'($urandom);
        model_alu(c, aa, bb, e, o);
        if (wrong) begin
            if ($urandom_range(0, 1) == 0) e = e ^ W'($urandom_range(1, 2**W - 1));
            else o = ~o;
        end
        send(c, aa, bb, e, o);
    endtask

    task automatic do_reset();
        v = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        v = 1'b0; control = '0; a = '0; b = '0; res = '0; ov = 1'b0;
        reset_n = 1'b1;
        model_clear();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({ready_o, done_o, err_v_o, pass_cnt_o, err_cnt_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b done=%b err_v=%b pass=%0d err=%0d, required all 0",
                     ready_o, done_o, err_v_o, pass_cnt_o, err_cnt_o);
        end
        checks++;
        if ({err_control_o, err_a_o, err_b_o, err_res_o, err_exp_o} !== '0) begin
            failures++;
            $display("FAIL reset_err_fields: got %h, required 0",
                     {err_control_o, err_a_o, err_b_o, err_res_o, err_exp_o});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready=%b done=%b, required ready=1 done=0", ready_o, done_o);
        end
    endtask

    task automatic test_op_sweep();
        logic [W-1:0] exp_tab [4];
        int           prev;
        exp_tab[0] = 4'b0100; exp_tab[1] = 4'b1110; exp_tab[2] = 4'b0001; exp_tab[3] = 4'b0011;
        for (int op = 0; op < 4; op++) begin
            prev = int'(pass_cnt_o);
            send(2'(op), 4'd1, 4'd3, exp_tab[op], 1'b0);
            v = 1'b0;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (int'(pass_cnt_o) !== prev) begin
                failures++;
                $display("FAIL sweep_latency op=%0d: pass_cnt=%0d one cycle after transfer, required %0d",
                         op, pass_cnt_o, prev);
            end
            @(negedge clk);
            checks++;
            if (int'(pass_cnt_o) !== prev + 1 || err_cnt_o !== '0) begin
                failures++;
                $display("FAIL sweep_count op=%0d: pass=%0d err=%0d, required pass=%0d err=0",
                         op, pass_cnt_o, err_cnt_o, prev + 1);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send(2'd0, 4'b0111, 4'b0001, 4'b1000, 1'b1);
        send(2'd1, 4'b1000, 4'b0001, 4'b0111, 1'b1);
        send(2'd0, 4'b0111, 4'b0001, 4'b1000, 1'b0);
        v = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pass_cnt_o !== 8'd2 || err_cnt_o !== 8'd1 || err_v_o !== 1'b1) begin
            failures++;
            $display("FAIL overflow_counts: pass=%0d err=%0d err_v=%b, required 2 1 1",
                     pass_cnt_o, err_cnt_o, err_v_o);
        end
        checks++;
        if (err_exp_o !== 4'b1000 || err_res_o !== 4'b1000 || err_control_o !== 2'd0) begin
            failures++;
            $display("FAIL overflow_capture: exp=%b res=%b ctl=%0d, required exp=1000 res=1000 ctl=0",
                     err_exp_o, err_res_o, err_control_o);
        end
    endtask

    task automatic test_mismatch_capture();
        do_reset();
        for (int i = 1; i <= 6; i++) send_rand(i == 3 || i == 5);
        v = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt_o !== 8'd2 || pass_cnt_o !== 8'd4 || err_v_o !== 1'b1) begin
            failures++;
            $display("FAIL mismatch_counts: pass=%0d err=%0d err_v=%b, required 4 2 1",
                     pass_cnt_o, err_cnt_o, err_v_o);
        end
        checks++;
        if ({err_control_o, err_a_o, err_b_o, err_res_o, err_exp_o} !== {m_ec, m_ea, m_eb, m_eres, m_eexp}) begin
            failures++;
            $display("FAIL mismatch_fields: got %h, required %h (transaction 3)",
                     {err_control_o, err_a_o, err_b_o, err_res_o, err_exp_o}, {m_ec, m_ea, m_eb, m_eres, m_eexp});
        end
    endtask

    task automatic test_back_to_back();
        int seen;
        do_reset();
        for (int i = 0; i < N; i++) send_rand(1'b0);
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_drop: ready=%b done=%b after 16th transfer, required 0 0", ready_o, done_o);
        end
        seen = -1;
        for (int i = 0; i < 20 && seen < 0; i++) begin
            if (done_o === 1'b1) seen = cyc;
            else @(negedge clk);
        end
        checks++;
        if (seen - m_last_cyc !== 2) begin
            failures++;
            $display("FAIL b2b_done_latency: done seen %0d cycles after last transfer, required 2",
                     seen - m_last_cyc);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (int'(pass_cnt_o) + int'(err_cnt_o) !== N || int'(pass_cnt_o) !== m_pass || ready_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_totals: pass=%0d err=%0d ready=%b with v held, required pass=%0d err=%0d ready=0",
                     pass_cnt_o, err_cnt_o, ready_o, m_pass, m_err);
        end
        v = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        int seen;
        do_reset();
        for (int i = 0; i < 5; i++) send_rand(i == 1);
        v = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({ready_o, done_o, err_v_o, pass_cnt_o, err_cnt_o, err_exp_o} !== '0) begin
            failures++;
            $display("FAIL midreset_clear: ready=%b done=%b err_v=%b pass=%0d err=%0d, required all 0",
                     ready_o, done_o, err_v_o, pass_cnt_o, err_cnt_o);
        end
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < N - 1; i++) send_rand(1'b0);
        v = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || int'(pass_cnt_o) !== N - 1) begin
            failures++;
            $display("FAIL midreset_partial: done=%b pass=%0d after 15 fresh transfers, required done=0 pass=15",
                     done_o, pass_cnt_o);
        end
        send_rand(1'b0);
        v = 1'b0;
        seen = -1;
        for (int i = 0; i < 10 && seen < 0; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) seen = cyc;
        end
        checks++;
        if (seen < 0 || int'(pass_cnt_o) !== N) begin
            failures++;
            $display("FAIL midreset_done: done=%b pass=%0d after 16 fresh transfers, required done=1 pass=16",
                     done_o, pass_cnt_o);
        end
    endtask

    task automatic test_idle_gaps();
        int seen;
        do_reset();
        for (int i = 0; i < N; i++) begin
            v = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (done_o !== 1'b0) begin
                failures++;
                $display("FAIL idle_early_done: done=1 after %0d transfers, required 0", m_sent);
            end
            send_rand($urandom_range(0, 4) == 0);
        end
        v = 1'b0;
        seen = -1;
        for (int i = 0; i < 10 && seen < 0; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) seen = cyc;
        end
        checks++;
        if (seen < 0 || int'(pass_cnt_o) !== m_pass || int'(err_cnt_o) !== m_err || m_pass + m_err !== N) begin
            failures++;
            $display("FAIL idle_counts: done=%b pass=%0d err=%0d, required done=1 pass=%0d err=%0d",
                     done_o, pass_cnt_o, err_cnt_o, m_pass, m_err);
        end
        checks++;
        if (err_v_o !== m_err_v ||
            (m_err_v && {err_control_o, err_a_o, err_b_o, err_res_o, err_exp_o} !== {m_ec, m_ea, m_eb, m_eres, m_eexp})) begin
            failures++;
            $display("FAIL idle_capture: err_v=%b fields=%h, required err_v=%b fields=%h", err_v_o,
                     {err_control_o, err_a_o, err_b_o, err_res_o, err_exp_o}, m_err_v, {m_ec, m_ea, m_eb, m_eres, m_eexp});
        end
    endtask

    initial begin
        test_reset();
        test_op_sweep();
        test_overflow();
        test_mismatch_capture();
        test_back_to_back();
        test_reset_mid_stream();
        test_idle_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_alu_checker.md
Name: bsg_alu_checker

Overview:
Response-side companion to bsg_alu. It consumes completed ALU transactions (control, operands, DUT result, DUT overflow) over a valid/ready handshake and recomputes the golden result in a registered pipeline. It compares the DUT values against that golden result, counts passes and mismatches, and captures the first mismatch. After a programmed number of transactions it raises done. It sits downstream of the ALU in benches and in on-chip BIST wrappers.

Parameters:
width_p, 4, operand/result width in bits (>=2)
num_ops_p, 16, transactions checked before done (>=1)
cnt_width_p, 8, width of pass/error counters (must satisfy 2^cnt_width_p > num_ops_p)

Ports:
clk_i  input  1  clock
reset_n_i  input  1  asynchronous active-low reset
v_i  input  1  transaction valid
ready_o  output  1  checker can accept
control_i  input  2  ALU op: 00 add, 01 sub, 10 and, 11 or
a_i  input  width_p  operand a
b_i  input  width_p  operand b
res_i  input  width_p  DUT result
ov_i  input  1  DUT overflow
done_o  output  1  num_ops_p transactions checked and retired
pass_cnt_o  output  cnt_width_p  matching transactions
err_cnt_o  output  cnt_width_p  mismatching transactions
err_v_o  output  1  at least one mismatch captured
err_control_o  output  2  control of first mismatch
err_a_o  output  width_p  a of first mismatch
err_b_o  output  width_p  b of first mismatch
err_res_o  output  width_p  DUT res of first mismatch
err_exp_o  output  width_p  golden res of first mismatch

Behaviour:
- Reset: one clock; reset_n_i is asynchronous, active-low. While reset is asserted, all flops clear: state=eRun, accept count=0, pipe valids=0, counters=0, err_v_o=0, err_* fields=0, done_o=0. ready_o is 0 while reset_n_i=0.
- Handshake: a transfer occurs on a posedge with v_i & ready_o. ready_o = (state==eRun) & (accepted < num_ops_p). ready_o does not depend on v_i. Inputs are don't-care when v_i=0.
- Golden model, computed modulo 2^width_p:
  - add: exp=a+b; ov=signed overflow (a,b same sign, result sign differs).
  - sub: exp=a-b; ov=signed overflow (a,b signs differ, result sign differs from a).
  - and, or: exp=a&b or a|b; ov=0.
- Pipeline: stage 1 registers the transaction and the computed exp/ov. Stage 2 registers match=(res==exp)&(ov==exp_ov). The counter update happens at the end of stage 2. Latency is 2 cycles from transfer to counter update. Throughput is 1 per cycle with no bubbles.
- First-error capture: on the first retiring mismatch, set err_v_o and latch the err_* fields. Later mismatches only increment err_cnt_o.
- Counters saturate at all-ones. Saturation is unreachable when the parameter rule holds.
- FSM states:
  - eRun: accepting. When accepted==num_ops_p and both pipe stages are empty, go to eDone.
  - eDone: done_o=1, ready_o=0. Sticky until reset.
- Invariant: in eDone, pass_cnt_o + err_cnt_o == num_ops_p.
- Reset mid-operation: in-flight pipe contents are discarded and no partial count survives.
- v_i held high while ready_o=0: no transfer occurs and no counter changes.

Decomposition:
- Package bsg_alu_pkg holds:
  - enum bsg_alu_op_e {eAdd, eSub, eAnd, eOr} (2 bits), shared with bsg_alu.
  - checker state enum {eRun, eDone}.
- One sub-module: bsg_alu_golden, a combinational reference model (control, a, b -> exp, exp_ov). The same module is reusable as the ALU's behavioural twin.

Test Plan:
- Sweep all 4 ops with width_p=4, a=1, b=3, correct DUT values: add res 0100/ov0; sub res 1110/ov0; and 0001; or 0011. Required: pass_cnt increments 2 cycles after each transfer, err_cnt=0.
- Overflow cases: add 0111+0001 -> exp 1000, ov=1; sub 1000-0001 -> exp 0111, ov=1. Driving ov_i=0 on the add case gives err_cnt=1 and err_exp_o=1000.
- Mismatch capture: inject wrong res on transactions 3 and 5. Required: err_cnt=2, err_* fields hold transaction 3 values, err_v_o=1.
- Backpressure/end: drive num_ops_p=16 transactions back-to-back with v_i held high. Required: ready_o drops after the 16th transfer, done_o rises 2 cycles later, and pass+err=16.
- Reset mid-stream: assert reset_n_i low asynchronously after 5 transfers (between clock edges). Required: all outputs clear immediately; after release, 16 fresh transfers are needed to reach done.
- Idle gaps: random v_i deassertion. Required: counts unaffected and done_o only after exactly num_ops_p transfers.
